// File: rtl/datareq_reply_fetch_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : datareq_reply_fetch_if
// Brief    : Request, DATAREQ memory handshake, reply stream and status bundle.
// Revision : 1.0
// ----------------------------------------------------------------------------
interface datareq_reply_fetch_if;
  logic        req_valid;
  logic [47:0] req_tag;
  logic        req_ready;
  logic        start_event_req;
  logic        data_ready;
  logic [15:0] packets_in_event;
  logic        last_word;
  logic        re_fifo;
  logic [63:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic        clr_err;
  logic [31:0] evt_cnt;
  logic [31:0] word_cnt;
  logic        err_seq;
  logic        err_timeout;
  logic        err_lastword;

  modport master (
    input  req_valid, req_tag, data_ready, packets_in_event, last_word,
           data_in, out_ready, clr_err,
    output req_ready, start_event_req, re_fifo, out_valid, out_data,
           out_sop, out_eop, evt_cnt, word_cnt, err_seq, err_timeout,
           err_lastword
  );

  modport slave (
    output req_valid, req_tag, data_ready, packets_in_event, last_word,
           data_in, out_ready, clr_err,
    input  req_ready, start_event_req, re_fifo, out_valid, out_data,
           out_sop, out_eop, evt_cnt, word_cnt, err_seq, err_timeout,
           err_lastword
  );
endinterface
`default_nettype wire

// File: rtl/datareq_reply_fetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : datareq_reply_fetch
// Brief    : Fetches one DATAREQ event per request and streams header + payload.
// Revision : 1.0
// ----------------------------------------------------------------------------
module datareq_reply_fetch #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int WAIT_RD        = 2
) (
  input  logic                         readout_clk,
  input  logic                         reset,
  datareq_reply_fetch_if.master        bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_HDR   = 3'd2;
  localparam logic [2:0] S_PULSE = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;
  localparam logic [2:0] S_DRAIN = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [47:0] tag_q, tag_d;
  logic [15:0] p_q, p_d;
  logic [16:0] r_q, r_d;
  logic [31:0] tmo_q, tmo_d;
  logic [15:0] wait_q, wait_d;
  logic [31:0] prev_q, prev_d;
  logic        first_q, first_d;
  logic        lw_seen_q, lw_seen_d;
  logic        req_ready_q, req_ready_d;
  logic        start_q, start_d;
  logic        re_fifo_q, re_fifo_d;
  logic        out_valid_q, out_valid_d;
  logic [63:0] out_data_q, out_data_d;
  logic        out_sop_q, out_sop_d;
  logic        out_eop_q, out_eop_d;
  logic [31:0] evt_cnt_q, evt_cnt_d;
  logic [31:0] word_cnt_q, word_cnt_d;
  logic        err_seq_q, err_seq_d;
  logic        err_tmo_q, err_tmo_d;
  logic        err_lw_q, err_lw_d;
  logic        set_seq, set_tmo, set_lw;
  logic        hs;

  assign hs = out_valid_q & bus.out_ready;

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    p_d         = p_q;
    r_d         = r_q;
    tmo_d       = tmo_q;
    wait_d      = wait_q;
    prev_d      = prev_q;
    first_d     = first_q;
    lw_seen_d   = lw_seen_q;
    req_ready_d = req_ready_q;
    start_d     = start_q;
    re_fifo_d   = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    evt_cnt_d   = evt_cnt_q;
    word_cnt_d  = word_cnt_q;
    set_seq     = 1'b0;
    set_tmo     = 1'b0;
    set_lw      = 1'b0;

    if ((state_q inside {S_PULSE, S_WAIT, S_OUT, S_DRAIN}) && bus.last_word)
      lw_seen_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          tag_d       = bus.req_tag;
          req_ready_d = 1'b0;
          start_d     = 1'b1;
          tmo_d       = 32'd0;
          lw_seen_d   = 1'b0;
          first_d     = 1'b1;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.data_ready) begin
          p_d         = bus.packets_in_event;
          r_d         = {bus.packets_in_event, 1'b0};
          start_d     = 1'b0;
          out_valid_d = 1'b1;
          out_data_d  = {tag_q, bus.packets_in_event};
          out_sop_d   = 1'b1;
          out_eop_d   = (bus.packets_in_event == 16'd0);
          state_d     = S_HDR;
        end else if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
          set_tmo     = 1'b1;
          p_d         = 16'd0;
          r_d         = 17'd0;
          start_d     = 1'b0;
          out_valid_d = 1'b1;
          out_data_d  = {tag_q, 16'd0};
          out_sop_d   = 1'b1;
          out_eop_d   = 1'b1;
          state_d     = S_HDR;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      S_HDR: begin
        if (hs) begin
          out_valid_d = 1'b0;
          out_sop_d   = 1'b0;
          out_eop_d   = 1'b0;
          if (p_q == 16'd0) begin
            state_d = S_DRAIN;
          end else begin
            re_fifo_d = 1'b1;
            state_d   = S_PULSE;
          end
        end
      end
      S_PULSE: begin
        wait_d  = 16'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Sample lands WAIT_RD cycles after the pulse cycle.
        if (wait_q == 16'(WAIT_RD - 1)) begin
          out_valid_d = 1'b1;
          out_data_d  = bus.data_in;
          out_eop_d   = (r_q == 17'd1);
          if (bus.data_in[63:32] != bus.data_in[31:0] + 32'd1)
            set_seq = 1'b1;
          if (!first_q && (bus.data_in[31:0] != prev_q + 32'd2))
            set_seq = 1'b1;
          prev_d  = bus.data_in[31:0];
          first_d = 1'b0;
          state_d = S_OUT;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_OUT: begin
        if (hs) begin
          out_valid_d = 1'b0;
          out_eop_d   = 1'b0;
          r_d         = r_q - 17'd1;
          word_cnt_d  = word_cnt_q + 32'd1;
          if (r_q == 17'd1) begin
            state_d = S_DRAIN;
          end else begin
            re_fifo_d = 1'b1;
            state_d   = S_PULSE;
          end
        end
      end
      S_DRAIN: begin
        // Holding here keeps start_event_req low until the memory side releases.
        if (!bus.data_ready) begin
          evt_cnt_d   = evt_cnt_q + 32'd1;
          req_ready_d = 1'b1;
          if ((p_q != 16'd0) && !(lw_seen_q || bus.last_word))
            set_lw = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        start_d     = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase

    err_seq_d = (err_seq_q & ~bus.clr_err) | set_seq;
    err_tmo_d = (err_tmo_q & ~bus.clr_err) | set_tmo;
    err_lw_d  = (err_lw_q  & ~bus.clr_err) | set_lw;
  end

  always_ff @(posedge readout_clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tag_q       <= 48'd0;
      p_q         <= 16'd0;
      r_q         <= 17'd0;
      tmo_q       <= 32'd0;
      wait_q      <= 16'd0;
      prev_q      <= 32'd0;
      first_q     <= 1'b1;
      lw_seen_q   <= 1'b0;
      req_ready_q <= 1'b1;
      start_q     <= 1'b0;
      re_fifo_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 64'd0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      evt_cnt_q   <= 32'd0;
      word_cnt_q  <= 32'd0;
      err_seq_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
      err_lw_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      p_q         <= p_d;
      r_q         <= r_d;
      tmo_q       <= tmo_d;
      wait_q      <= wait_d;
      prev_q      <= prev_d;
      first_q     <= first_d;
      lw_seen_q   <= lw_seen_d;
      req_ready_q <= req_ready_d;
      start_q     <= start_d;
      re_fifo_q   <= re_fifo_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      evt_cnt_q   <= evt_cnt_d;
      word_cnt_q  <= word_cnt_d;
      err_seq_q   <= err_seq_d;
      err_tmo_q   <= err_tmo_d;
      err_lw_q    <= err_lw_d;
    end
  end

  assign bus.req_ready       = req_ready_q;
  assign bus.start_event_req = start_q;
  assign bus.re_fifo         = re_fifo_q;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_data        = out_data_q;
  assign bus.out_sop         = out_sop_q;
  assign bus.out_eop         = out_eop_q;
  assign bus.evt_cnt         = evt_cnt_q;
  assign bus.word_cnt        = word_cnt_q;
  assign bus.err_seq         = err_seq_q;
  assign bus.err_timeout     = err_tmo_q;
  assign bus.err_lastword    = err_lw_q;

endmodule
`default_nettype wire

// File: doc/datareq_reply_fetch.md
# datareq_reply_fetch

Downstream consumer of the DDR simulator and DDR3 read path. It accepts one data request at a time and drives the DATAREQ start/read-enable handshake toward the memory side. It pulls the event's 64-bit words out, one edge-detected read pulse per word, and presents them as a framed stream (header, then payload) to the DTC reply formatter. It also checks the simulator's counting pattern and flags timeouts.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 1024: cycles to wait for `data_ready` after the request is asserted.
- `WAIT_RD`, default 2: cycles from the read-pulse cycle to data sampling; must be 2 or more.

Ports:
- `readout_clk`  in  1  — 40 MHz ALGO_CLK; sole clock.
- `reset`  in  1  — synchronous, active-high.
- `req_valid`  in  1  — data request pending.
- `req_tag`  in  48  — event window tag of the request.
- `req_ready`  out  1  — block idle; request accepted when `req_valid && req_ready`.
- `start_event_req`  out  1  — to DATAREQ_START_EVENT_REQ (memory `fifo_read_mem_en`).
- `data_ready`  in  1  — DATAREQ_DATA_READY_FLAG.
- `packets_in_event`  in  16  — DATAREQ_PACKETS_IN_EVENT; each packet is 2 words.
- `last_word`  in  1  — DATAREQ_LAST_WORD_FLAG; monitored only.
- `re_fifo`  out  1  — DATAREQ_RE_FIFO read pulse.
- `data_in`  in  64  — DATAREQ_DATA_REQ_REPLY.
- `out_valid`  out  1  — output word valid.
- `out_ready`  in  1  — downstream accepts the word.
- `out_data`  out  64  — output word.
- `out_sop`  out  1  — header word marker.
- `out_eop`  out  1  — last word of the event.
- `clr_err`  in  1  — clears the sticky error flags.
- `evt_cnt`  out  32  — completed events; wraps.
- `word_cnt`  out  32  — payload words delivered; wraps.
- `err_seq`  out  1  — sticky; payload pattern mismatch.
- `err_timeout`  out  1  — sticky; `data_ready` timeout.
- `err_lastword`  out  1  — sticky; `last_word` was never seen on a non-empty event.

## Operation

All outputs are registered. On `reset`, every output is 0 except `req_ready`, which is 1. All counters and flags clear, and the FSM returns to IDLE.

FSM states and transitions:
- **IDLE**
  - `req_ready=1`.
  - On accept: latch `req_tag`, go to REQ.
- **REQ**
  - `start_event_req=1`; the timeout counter runs.
  - On `data_ready=1`:
    - latch `packets_in_event` into P (16 b);
    - load the remaining-word count R = 2·P (17 b);
    - drop `start_event_req`;
    - go to HDR.
  - When the counter reaches `TIMEOUT_CYCLES` first:
    - set `err_timeout`;
    - set P=0;
    - drop `start_event_req`;
    - go to HDR.
- **HDR**
  - Present `out_data = {tag[47:0], P[15:0]}` with `out_sop=1`, and `out_eop=1` iff P==0.
  - On `out_valid && out_ready`:
    - if P==0, go to DRAIN;
    - otherwise go to PULSE.
- **PULSE**: `re_fifo=1` for exactly one cycle, then go to WAIT.
- **WAIT**: hold `WAIT_RD`−1 cycles with `re_fifo=0`, then capture `data_in` and go to OUT.
- **OUT**
  - Present the captured word; `out_eop=1` when R==1.
  - On handshake:
    - decrement R;
    - increment `word_cnt`;
    - if R becomes 0, go to DRAIN;
    - otherwise go to PULSE.
- **DRAIN**
  - Wait for `data_ready==0`, then increment `evt_cnt` and go to IDLE.
  - `start_event_req` must not re-rise before `data_ready` falls, so the memory side never sees a second request edge for the same event.

Pattern check, applied to every captured word w:
- require `w[63:32] == w[31:0]+1`;
- for every word after the first in an event, require `w[31:0] == prev[31:0]+2`;
- all additions are mod 2^32;
- any violation sets `err_seq`.

Last-word check:
- `last_word` is sampled during PULSE/WAIT/OUT/DRAIN.
- If it was never seen while R>0 or in DRAIN, `err_lastword` is set at the DRAIN exit.

Error flags:
- Sticky until `clr_err` or `reset`.
- If `clr_err` and a new error fall in the same cycle, the new error wins (flag stays 1).

## Timing

- Accept to `start_event_req` high: 1 cycle.
- `data_ready` sampled high to header `out_valid`: 1 cycle.
- Read pulse spacing:
  - `re_fifo` is always a single-cycle pulse separated by at least `WAIT_RD` low cycles, because the memory side edge-detects it.
  - With `out_ready` tied high, the per-word period is `WAIT_RD`+2 cycles.
- `data_in` is sampled exactly `WAIT_RD` cycles after the `re_fifo` high cycle.
- Output hold:
  - `out_valid` stays asserted and `out_data`/`out_sop`/`out_eop` stay stable until `out_ready`.
  - Backpressure never generates extra `re_fifo` pulses.
- `reset` mid-event: the next cycle is IDLE, all outputs are at their reset values, and the partial event is discarded.
- `req_valid` is ignored outside IDLE.

## Test plan

1. **Normal event.** Memory side DDR3-full with P=0x40, `out_ready`=1 → header `{tag,0x0040}` with sop. Then 128 payload words:
   - first word 0x00000001_00000000;
   - last word 0x000000FF_000000FE, with eop.
   - After the event, `evt_cnt`=1, `word_cnt`=128, no errors.
2. **Back-to-back events.** Two events → second event's first word is 0x00000101_00000100; exactly 2 rising edges on `start_event_req`.
3. **Empty reply.** DDR3 not full (P=0, `data_ready` high for 8 cycles) → single header word with sop=eop=1; no `re_fifo` pulses; IDLE only after `data_ready` falls.
4. **Backpressure.** `out_ready` toggles at 1/3 duty → same 129 words in order; `re_fifo` count is 128, and each pulse lasts 1 cycle.
5. **Pattern error and timeout.**
   - Corrupt word 5's high half → `err_seq`=1 until `clr_err`.
   - Never assert `data_ready` → after 1024 cycles, header with P=0 and eop, `err_timeout`=1.
6. **Reset mid-payload.** Assert `reset` after word 10 → next cycle `req_ready`=1, all other outputs 0, counters 0.
